// File: rtl/func_unit_pkg.sv
// -----------------------------------------------------------------------------
// func_unit_pkg
//   Definitions shared by the functional-unit decoder and encoder:
//   - fu_type_e   : 3-bit micro-op type code (110/111 are illegal)
//   - OPC_*       : 11-bit R-format opcodes
//   - SH_*        : fixed shift-field values for ops that do not use shammt
//   - *_LSB/_W    : R-format field positions
//   - rfmt_word() : packs the fields into a 32-bit instruction word
// -----------------------------------------------------------------------------
package func_unit_pkg;

  typedef enum logic [2:0] {
    FU_ADD  = 3'b000,
    FU_SUB  = 3'b001,
    FU_MUL  = 3'b010,
    FU_UDIV = 3'b011,
    FU_FADD = 3'b100,
    FU_FSUB = 3'b101
  } fu_type_e;

  localparam int INSTR_W = 32;

  // Opcodes, bits [31:21] of the instruction word.
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_MUL  = 11'b10011011000;
  localparam logic [10:0] OPC_UDIV = 11'b10011010110;
  localparam logic [10:0] OPC_FP   = 11'b00011110011;

  // Fixed shift-field values; FADD and FSUB share an opcode and are told
  // apart only by this field.
  localparam logic [5:0] SH_MUL  = 6'b011111;
  localparam logic [5:0] SH_UDIV = 6'b000010;
  localparam logic [5:0] SH_FADD = 6'b001010;
  localparam logic [5:0] SH_FSUB = 6'b001110;

  // R-format field positions: {opc, Rm, sh, Rn, Rd}.
  localparam int RD_LSB  = 0;
  localparam int RD_W    = 5;
  localparam int RN_LSB  = 5;
  localparam int RN_W    = 5;
  localparam int SH_LSB  = 10;
  localparam int SH_W    = 6;
  localparam int RM_LSB  = 16;
  localparam int RM_W    = 5;
  localparam int OPC_LSB = 21;
  localparam int OPC_W   = 11;

  function automatic logic [INSTR_W-1:0] rfmt_word(
    input logic [OPC_W-1:0] opc,
    input logic [RM_W-1:0]  rm,
    input logic [SH_W-1:0]  sh,
    input logic [RN_W-1:0]  rn,
    input logic [RD_W-1:0]  rd
  );
    logic [INSTR_W-1:0] word;
    word = '0;
    word[OPC_LSB +: OPC_W] = opc;
    word[RM_LSB  +: RM_W]  = rm;
    word[SH_LSB  +: SH_W]  = sh;
    word[RN_LSB  +: RN_W]  = rn;
    word[RD_LSB  +: RD_W]  = rd;
    return word;
  endfunction

endpackage

// File: rtl/func_unit_encoder_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with extra-MSB pointers (full = MSBs differ and the
//   index bits match; empty = pointers equal). Push while full and pop while
//   empty are ignored. clear empties the FIFO and beats push/pop.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     clear          synchronous flush
//     push, wdata    write request and data
//     pop            read request (head advances)
//     rdata          head entry (undefined contents when empty)
//     full, empty    status
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are
  // valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/func_unit_encoder.sv
// -----------------------------------------------------------------------------
// func_unit_encoder
//   Encodes decoded micro-ops into 32-bit R-format words, buffers them in a
//   FIFO and emits them as addressed instruction-memory write beats.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     clear             synchronous flush (FIFO, address, illegal flag)
//     in_valid/in_ready micro-op handshake
//     type_instruction  op type (see func_unit_pkg::fu_type_e)
//     regnum_1/2        Rn / Rm source registers
//     dest_reg          Rd
//     shammt            shift amount, used by ADD/SUB only
//     out_valid/ready   write-beat handshake
//     out_data/addr     encoded word and its byte address
//     illegal_err       sticky: an illegal type was accepted
//     words_emitted     saturating count of completed beats
// -----------------------------------------------------------------------------
module func_unit_encoder
  import func_unit_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  type_instruction,
  input  logic [4:0]  regnum_1,
  input  logic [4:0]  regnum_2,
  input  logic [4:0]  dest_reg,
  input  logic [5:0]  shammt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_addr,
  output logic        illegal_err,
  output logic [15:0] words_emitted
);

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (MEM_WORDS - 1));

  logic [OPC_W-1:0]   enc_opc;
  logic [SH_W-1:0]    enc_sh;
  logic               enc_legal;
  logic [INSTR_W-1:0] enc_word;

  logic               fifo_full;
  logic               fifo_empty;
  logic [INSTR_W-1:0] fifo_rdata;
  logic               accept;
  logic               push;
  logic               pop;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned (which would infer a latch).
  always_comb begin
    enc_opc   = '0;
    enc_sh    = '0;
    enc_legal = 1'b1;
    case (type_instruction)
      FU_ADD:  begin enc_opc = OPC_ADD;  enc_sh = shammt;  end
      FU_SUB:  begin enc_opc = OPC_SUB;  enc_sh = shammt;  end
      FU_MUL:  begin enc_opc = OPC_MUL;  enc_sh = SH_MUL;  end
      FU_UDIV: begin enc_opc = OPC_UDIV; enc_sh = SH_UDIV; end
      FU_FADD: begin enc_opc = OPC_FP;   enc_sh = SH_FADD; end
      FU_FSUB: begin enc_opc = OPC_FP;   enc_sh = SH_FSUB; end
      default: enc_legal = 1'b0;
    endcase
    enc_word = rfmt_word(enc_opc, regnum_2, enc_sh, regnum_1, dest_reg);
  end

  // Illegal ops are consumed (handshake completes) but never buffered.
  // A handshake coincident with clear is dropped entirely.
  assign in_ready  = !fifo_full;
  assign accept    = in_valid && in_ready && !clear;
  assign push      = accept && enc_legal;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready && !clear;
  assign out_data  = fifo_empty ? '0 : fifo_rdata;

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (enc_word),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Beat address: advances per completed beat, wrapping at the memory end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_addr <= BASE_ADDR;
    end else if (clear) begin
      out_addr <= BASE_ADDR;
    end else if (pop) begin
      out_addr <= (out_addr == LAST_ADDR) ? BASE_ADDR : out_addr + 32'd4;
    end
  end

  // Sticky illegal flag; only reset and clear drop it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_err <= 1'b0;
    end else if (clear) begin
      illegal_err <= 1'b0;
    end else if (accept && !enc_legal) begin
      illegal_err <= 1'b1;
    end
  end

  // Lifetime beat count; survives clear, saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_emitted <= '0;
    end else if (pop && (words_emitted != 16'hFFFF)) begin
      words_emitted <= words_emitted + 16'd1;
    end
  end

endmodule

// File: tb/tb_func_unit_encoder.sv
// -----------------------------------------------------------------------------
// tb_func_unit_encoder
//   Table-driven encoding vectors, directed multi-cycle sequences and random
//   traffic. A negedge monitor compares every output against a queue-based
//   reference model each cycle.
// -----------------------------------------------------------------------------
module tb_func_unit_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          MW    = 4;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  type_instruction;
  logic [4:0]  regnum_1;
  logic [4:0]  regnum_2;
  logic [4:0]  dest_reg;
  logic [5:0]  shammt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic        illegal_err;
  logic [15:0] words_emitted;

  func_unit_encoder #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .MEM_WORDS (MW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear            (clear),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .type_instruction (type_instruction),
    .regnum_1         (regnum_1),
    .regnum_2         (regnum_2),
    .dest_reg         (dest_reg),
    .shammt           (shammt),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_addr         (out_addr),
    .illegal_err      (illegal_err),
    .words_emitted    (words_emitted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_word(input int t, input int rn, input int rm,
                                           input int rd, input int sh, output bit legal);
    int opc;
    int s;
    legal = 1'b1;
    opc   = 0;
    s     = sh;
    case (t)
      0: opc = 'b10001011000;
      1: opc = 'b11001011000;
      2: begin opc = 'b10011011000; s = 31; end
      3: begin opc = 'b10011010110; s = 2;  end
      4: begin opc = 'b00011110011; s = 10; end
      5: begin opc = 'b00011110011; s = 14; end
      default: legal = 1'b0;
    endcase
    return 32'(opc * (1 << 21) + rm * (1 << 16) + s * (1 << 10) + rn * 32 + rd);
  endfunction

  logic [31:0] mq[$];
  int          m_idx;
  bit          m_ill;
  int          m_emit;
  bit          mon_en = 1'b0;

  task automatic model_reset();
    mq.delete();
    m_idx  = 0;
    m_ill  = 1'b0;
    m_emit = 0;
  endtask

  // Compare outputs against the model, then advance the model for the coming edge.
  always @(negedge clk) begin : monitor
    bit          ready;
    bit          legal;
    logic [31:0] w;
    if (mon_en && rst_n) begin
      ready = (mq.size() < DEPTH);
      check("in_ready", 32'(in_ready), 32'(ready));
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("out_data", out_data, (mq.size() != 0) ? mq[0] : 32'h0);
      check("out_addr", out_addr, BASE + 32'(4 * m_idx));
      check("illegal_err", 32'(illegal_err), 32'(m_ill));
      check("words_emitted", 32'(words_emitted), 32'(m_emit));
      if (clear) begin
        mq.delete();
        m_idx = 0;
        m_ill = 1'b0;
      end else begin
        w = ref_word(int'(type_instruction), int'(regnum_1), int'(regnum_2),
                     int'(dest_reg), int'(shammt), legal);
        if (mq.size() != 0 && out_ready) begin
          void'(mq.pop_front());
          m_idx = (m_idx + 1) % MW;
          if (m_emit < 65535) m_emit++;
        end
        if (in_valid && ready) begin
          if (legal) mq.push_back(w);
          else m_ill = 1'b1;
        end
      end
    end
  end

  // ---------------- drive helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [2:0] t, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic [5:0] sh);
    in_valid         = 1'b1;
    type_instruction = t;
    regnum_1         = r1;
    regnum_2         = r2;
    dest_reg         = rd;
    shammt           = sh;
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  t;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  rd;
    logic [5:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit          lg;
    int          acc;
    int          emit0;
    logic [31:0] first_w;

    vecs[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  6'd0,  32'h8B020023};  // ADD
    vecs[1] = '{3'd4, 5'd1,  5'd2,  5'd0,  6'd0,  32'h1E622820};  // FADD
    vecs[2] = '{3'd3, 5'd4,  5'd5,  5'd6,  6'd0,  32'h9AC50886};  // UDIV
    vecs[3] = '{3'd1, 5'd0,  5'd0,  5'd0,  6'd63, 32'hCB00FC00};  // SUB max shift
    vecs[4] = '{3'd2, 5'd31, 5'd31, 5'd31, 6'd5,  32'h9B1F7FFF};  // MUL, shammt ignored
    vecs[5] = '{3'd5, 5'd2,  5'd3,  5'd1,  6'd9,  32'h1E633841};  // FSUB, shammt ignored
    vecs[6] = '{3'd0, 5'd5,  5'd10, 5'd17, 6'd42, 32'h8B0AA8B1};  // ADD with shift

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    type_instruction = '0; regnum_1 = '0; regnum_2 = '0; dest_reg = '0; shammt = '0;
    #1;
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst out_data", out_data, 32'h0);
    check("rst out_addr", out_addr, BASE);
    step(); step();
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;

    // --- encoding table, one word at a time with single-cycle latency ---
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive_op(vecs[i].t, vecs[i].r1, vecs[i].r2, vecs[i].rd, vecs[i].sh);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d valid", i), 32'(out_valid), 32'h1);
      check($sformatf("vec%0d data", i), out_data, vecs[i].exp);
      step();
      if (i == 0) check("first words_emitted", 32'(words_emitted), 32'd1);
    end

    // --- back-to-back FADD, UDIV after clear: addresses 0 and 4 ---
    do_clear();
    drive_op(3'd4, 5'd1, 5'd2, 5'd0, 6'd0);
    step();
    drive_op(3'd3, 5'd4, 5'd5, 5'd6, 6'd0);
    @(negedge clk);
    check("b2b data0", out_data, 32'h1E622820);
    check("b2b addr0", out_addr, BASE);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b data1", out_data, 32'h9AC50886);
    check("b2b addr1", out_addr, BASE + 32'd4);
    step();

    // --- backpressure: 5 offered, 4 accepted, drain in order ---
    do_clear();
    out_ready = 1'b0;
    acc = 0;
    first_w = ref_word(1, 3, 4, 5, 6, lg);
    for (int i = 0; i < 5; i++) begin
      drive_op(3'd1, 5'(3 + i), 5'(4 + i), 5'(5 + i), 6'(6 + i));
      @(negedge clk);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("bp accepts", 32'(acc), 32'd4);
    check("bp in_ready low", 32'(in_ready), 32'h0);
    check("bp hold data", out_data, first_w);
    out_ready = 1'b1;
    step();
    check("bp in_ready after pop", 32'(in_ready), 32'h1);
    for (int i = 0; i < 4; i++) step();
    check("bp drained", 32'(out_valid), 32'h0);

    // --- illegal type between two ADDs ---
    do_clear();
    emit0 = m_emit;
    drive_op(3'd0, 5'd1, 5'd2, 5'd3, 6'd0); step();
    drive_op(3'd6, 5'd7, 5'd7, 5'd7, 6'd7); step();
    drive_op(3'd0, 5'd4, 5'd5, 5'd6, 6'd1); step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("illegal flag", 32'(illegal_err), 32'h1);
    check("illegal emitted", 32'(words_emitted), 32'(emit0 + 2));
    check("illegal next addr", out_addr, BASE + 32'd8);

    // --- address wrap with MEM_WORDS=4 ---
    do_clear();
    for (int k = 0; k < 5; k++) begin
      drive_op(3'd2, 5'(k), 5'(k), 5'(k), 6'd0);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("wrap addr%0d", k), out_addr, BASE + 32'(4 * (k % 4)));
      step();
    end

    // --- clear with two buffered words and a coincident input ---
    do_clear();
    out_ready = 1'b0;
    drive_op(3'd7, 5'd0, 5'd0, 5'd0, 6'd0); step();
    drive_op(3'd0, 5'd1, 5'd1, 5'd1, 6'd0); step();
    drive_op(3'd1, 5'd2, 5'd2, 5'd2, 6'd0); step();
    drive_op(3'd2, 5'd3, 5'd3, 5'd3, 6'd0);
    clear = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("clr out_valid", 32'(out_valid), 32'h0);
    check("clr out_addr", out_addr, BASE);
    check("clr illegal", 32'(illegal_err), 32'h0);
    out_ready = 1'b1;
    step(); step();
    check("clr nothing emitted", 32'(out_valid), 32'h0);

    // --- async reset mid-stall ---
    out_ready = 1'b0;
    drive_op(3'd6, 5'd0, 5'd0, 5'd0, 6'd0); step();
    drive_op(3'd0, 5'd1, 5'd1, 5'd1, 6'd0); step();
    drive_op(3'd1, 5'd2, 5'd2, 5'd2, 6'd0); step();
    in_valid = 1'b0;
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst out_valid", 32'(out_valid), 32'h0);
    check("arst out_data", out_data, 32'h0);
    check("arst out_addr", out_addr, BASE);
    check("arst illegal", 32'(illegal_err), 32'h0);
    check("arst words", 32'(words_emitted), 32'h0);
    step(); step();
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    out_ready = 1'b1;
    step(); step();
    check("arst no beat", 32'(out_valid), 32'h0);

    // --- random traffic against the model ---
    for (int c = 0; c < 800; c++) begin
      drive_op(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom),
               5'($urandom), 6'($urandom));
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 65);
      clear     = ($urandom_range(0, 99) < 3);
      step();
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("final drained", 32'(out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/func_unit_encoder.md
Name: func_unit_encoder

Overview:
Reverse-direction partner of the functional-unit decoder. It accepts decoded micro-op fields (type, source/dest registers, shift amount) over a valid/ready handshake and encodes them into 32-bit R-format instruction words. Encoded words are buffered in a small FIFO and emitted as addressed instruction-memory write beats. Used by the program loader and by the test harness to build instruction streams for the GPU cores.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
BASE_ADDR, 32'h0000_0000, byte address of the first emitted word
MEM_WORDS, 256, instruction-memory size in words; address wraps after the last word

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush
in_valid  in  1  micro-op valid
in_ready  out  1  encoder can accept
type_instruction  in  3  000 ADD, 001 SUB, 010 MUL, 011 UDIV, 100 FADD, 101 FSUB, 110/111 illegal
regnum_1  in  5  first source, goes to Rn [9:5]
regnum_2  in  5  second source, goes to Rm [20:16]
dest_reg  in  5  destination, goes to Rd [4:0]
shammt  in  6  shift amount for ADD/SUB; ignored otherwise
out_valid  out  1  write beat valid
out_ready  in  1  memory accepts beat
out_data  out  32  encoded instruction
out_addr  out  32  byte address of beat
illegal_err  out  1  sticky: an illegal type was accepted
words_emitted  out  16  count of completed beats, saturating at 16'hFFFF

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, out_valid=0, out_data=0, out_addr=BASE_ADDR, illegal_err=0, words_emitted=0. in_ready=1 from the first cycle after reset release.
- Encoding, combinational on the inputs at acceptance: word = {opc[10:0], Rm, sh[5:0], Rn, Rd}.
  - ADD: opc 10001011000, sh=shammt
  - SUB: opc 11001011000, sh=shammt
  - MUL: opc 10011011000, sh=011111
  - UDIV: opc 10011010110, sh=000010
  - FADD: opc 00011110011, sh=001010
  - FSUB: opc 00011110011, sh=001110
- Accept: in_valid && in_ready. in_ready = !full. There is no same-cycle bypass when full.
  - Legal type: push the word.
  - Illegal type: the beat is consumed but not pushed. illegal_err is set.
- Output: out_valid = !empty. out_data = head word when non-empty, 0 when empty. Pop on out_valid && out_ready.
  - out_data and out_valid must hold stable while out_valid && !out_ready.
- Latency: a word accepted in cycle N appears on out_valid/out_data in cycle N+1 if the FIFO was empty.
- Simultaneous push and pop: occupancy is unchanged. Pop and push on the same entry index are legal when occupancy is 1.
- Address: each pop advances out_addr by 4. After BASE_ADDR + 4*(MEM_WORDS-1), the next value is BASE_ADDR (wrap).
- words_emitted increments on each pop and saturates.
- clear has priority over push and pop in the same cycle. It empties the FIFO, sets out_addr=BASE_ADDR, and clears illegal_err. words_emitted is not cleared. A handshake coincident with clear is discarded.
- Reset asserted mid-stream drops all buffered words immediately. No partial beat is emitted.
- FIFO pointers are log2(DEPTH)+1 bits. full = MSBs differ and the rest are equal; empty = pointers equal.

Decomposition:
- Shared package func_unit_pkg holds:
  - the 3-bit type enum (shared with the decoder)
  - the 11-bit opcode constants
  - the fixed sh constants (MUL 011111, UDIV 000010, FADD 001010, FSUB 001110)
  - the R-format field positions
- Sub-module sync_fifo (parameterised WIDTH, DEPTH) holds storage and pointers.
- Encode logic and address/counter logic stay in the top module.

Test Plan:
- ADD r1=1, r2=2, dest=3, shammt=0, out_ready=1 -> cycle+1: out_data=32'h8B020023, out_addr=0, words_emitted=1.
- FADD r1=1, r2=2, dest=0, then UDIV r1=4, r2=5, dest=6, back-to-back -> out_data=32'h1E622820 at addr 0, then 32'h9AC50886 at addr 4.
- out_ready=0, push 5 legal ops with DEPTH=4 -> in_ready drops after 4 accepts and out_data holds the first word. Raise out_ready -> 4 words drain in order and in_ready returns high after the first pop.
- type=3'b110 accepted between two ADDs -> illegal_err=1, exactly 2 words emitted, addresses 0 and 4.
- MEM_WORDS=4, emit 5 words -> addresses 0, 4, 8, 12, 0.
- 2 words buffered, assert clear with in_valid=1 -> next cycle out_valid=0, out_addr=BASE_ADDR, illegal_err=0, and the coincident input is not emitted. Repeat with rst_n pulsed low mid-stall -> all outputs at reset values asynchronously.
